// File: rtl/ara_perf_pkg.sv
// Shared definitions for the Ara/CVA6 performance counter block: register
// offsets, STATUS bit positions and the counting-window FSM states.
package ara_perf_pkg;

  localparam int unsigned CntWidth  = 64;
  localparam int unsigned DataWidth = 32;
  localparam int unsigned DecWidth  = 6;

  localparam logic [DecWidth-1:0] OffCtrl   = 6'h00;
  localparam logic [DecWidth-1:0] OffStatus = 6'h04;
  localparam logic [DecWidth-1:0] OffRtLo   = 6'h08;
  localparam logic [DecWidth-1:0] OffRtHi   = 6'h0C;
  localparam logic [DecWidth-1:0] OffDcLo   = 6'h10;
  localparam logic [DecWidth-1:0] OffDcHi   = 6'h14;
  localparam logic [DecWidth-1:0] OffIcLo   = 6'h18;
  localparam logic [DecWidth-1:0] OffIcHi   = 6'h1C;
  localparam logic [DecWidth-1:0] OffSbLo   = 6'h20;
  localparam logic [DecWidth-1:0] OffSbHi   = 6'h24;
  localparam logic [DecWidth-1:0] OffClear  = 6'h28;

  localparam int unsigned StRunning   = 0;
  localparam int unsigned StPending   = 1;
  localparam int unsigned StSnapValid = 2;
  localparam int unsigned StOvf       = 3;
  localparam int unsigned StWidth     = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COUNTING = 2'd1,
    DRAINING = 2'd2
  } perf_state_e;

endpackage

// File: rtl/ara_perf_counter.sv
// 64-bit saturating event counter with synchronous clear. cnt_c is the count
// including this cycle's increment (clear excluded) so snapshots see it.
module ara_perf_counter
  import ara_perf_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  input  logic                inc,
  output logic [CntWidth-1:0] cnt_c,
  output logic                ovf_c
);

  logic [CntWidth-1:0] cnt_q;
  logic                sat_c;

  assign sat_c = &cnt_q;
  assign cnt_c = (inc && !sat_c) ? cnt_q + CntWidth'(1) : cnt_q;
  // An increment blocked by saturation is an overflow, unless cleared anyway
  assign ovf_c = inc & sat_c & ~clr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_c;
    end
  end

endmodule

// File: rtl/ara_perf_apb_regs.sv
// Vector runtime / CVA6 stall counter engine with APB register file.
// Stall counters are built only when ARA_PERF_STALL_CNT_EN is defined.
module ara_perf_apb_regs
  import ara_perf_pkg::*;
#(
  parameter int unsigned AddrWidth = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 vinsn_valid_i,
  input  logic                 ara_idle_i,
  input  logic                 dcache_miss_i,
  input  logic                 icache_miss_i,
  input  logic                 sb_full_i,
  input  logic                 psel_i,
  input  logic                 penable_i,
  input  logic                 pwrite_i,
  input  logic [AddrWidth-1:0] paddr_i,
  input  logic [DataWidth-1:0] pwdata_i,
  output logic [DataWidth-1:0] prdata_o,
  output logic                 pready_o,
  output logic                 pslverr_o,
  output logic                 hw_cnt_en_o,
  output logic                 snap_valid_o
);

  perf_state_e state_q, state_d;
  logic running_c, inc_c;

  logic ctrl_en_q, pending_q, snap_valid_q, ovf_q;
  logic [DataWidth-1:0] shadow_q;
  logic [CntWidth-1:0]  snap_rt_q, snap_dc_q, snap_ic_q, snap_sb_q;

  logic [DecWidth-1:0]  addr_c;
  logic                 access_c, mapped_c, ro_c, err_c, wr_c, rd_c;
  logic [DataWidth-1:0] rdata_c, shadow_d_c;
  logic                 shadow_ld_c;
  logic [StWidth-1:0]   status_c;
  logic                 en_c, clr_c, st_wr_c, snap_take_c, ovf_any_c, ovf_stall_c;
  logic [CntWidth-1:0]  cnt_rt_c;
  logic                 ovf_rt_c;
  logic                 unused_c;

  assign addr_c   = paddr_i[DecWidth-1:0];
  assign access_c = psel_i & penable_i;
  assign unused_c = ^{paddr_i, pwdata_i};

  always_comb begin
    status_c              = '0;
    status_c[StRunning]   = running_c;
    status_c[StPending]   = pending_q;
    status_c[StSnapValid] = snap_valid_q;
    status_c[StOvf]       = ovf_q;
  end

  // Address decode and read mux; lo reads stage the matching hi word
  always_comb begin
    mapped_c    = 1'b1;
    ro_c        = 1'b0;
    rdata_c     = '0;
    shadow_ld_c = 1'b0;
    shadow_d_c  = '0;
    case (addr_c)
      OffCtrl:   rdata_c = DataWidth'(ctrl_en_q);
      OffStatus: rdata_c = DataWidth'(status_c);
      OffRtLo: begin
        ro_c = 1'b1; rdata_c = snap_rt_q[31:0];
        shadow_ld_c = 1'b1; shadow_d_c = snap_rt_q[63:32];
      end
      OffDcLo: begin
        ro_c = 1'b1; rdata_c = snap_dc_q[31:0];
        shadow_ld_c = 1'b1; shadow_d_c = snap_dc_q[63:32];
      end
      OffIcLo: begin
        ro_c = 1'b1; rdata_c = snap_ic_q[31:0];
        shadow_ld_c = 1'b1; shadow_d_c = snap_ic_q[63:32];
      end
      OffSbLo: begin
        ro_c = 1'b1; rdata_c = snap_sb_q[31:0];
        shadow_ld_c = 1'b1; shadow_d_c = snap_sb_q[63:32];
      end
      OffRtHi, OffDcHi, OffIcHi, OffSbHi: begin
        ro_c = 1'b1; rdata_c = shadow_q;
      end
      OffClear:  rdata_c = '0;
      default:   mapped_c = 1'b0;
    endcase
  end

  assign err_c = access_c & (~mapped_c | (pwrite_i & ro_c) |
                             (~pwrite_i & (addr_c == OffClear)));
  assign wr_c  = access_c & pwrite_i & ~err_c;
  assign rd_c  = access_c & ~pwrite_i & ~err_c;

  assign prdata_o     = rd_c ? rdata_c : '0;
  assign pslverr_o    = err_c;
  assign pready_o     = 1'b1;
  assign hw_cnt_en_o  = ctrl_en_q;
  assign snap_valid_o = snap_valid_q;

  // A CTRL write steers the FSM in the same cycle it lands
  assign en_c        = (wr_c && addr_c == OffCtrl) ? pwdata_i[0] : ctrl_en_q;
  assign clr_c       = wr_c && (addr_c == OffClear) && pwdata_i[0];
  assign st_wr_c     = wr_c && (addr_c == OffStatus);
  assign snap_take_c = pending_q & ara_idle_i & ~vinsn_valid_i;
  assign ovf_any_c   = ovf_rt_c | ovf_stall_c;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (en_c && vinsn_valid_i) state_d = COUNTING;
      COUNTING: if (!en_c) state_d = ara_idle_i ? IDLE : DRAINING;
      DRAINING: begin
        if (ara_idle_i) state_d = IDLE;
        else if (en_c)  state_d = COUNTING;
      end
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    running_c = 1'b0;
    inc_c     = 1'b0;
    if (state_q != IDLE) begin
      running_c = 1'b1;
      inc_c     = 1'b1;
    end
  end

  ara_perf_counter u_cnt_rt (
    .clk   (clk_i),
    .rst_n (rst_ni),
    .clr   (clr_c),
    .inc   (inc_c),
    .cnt_c (cnt_rt_c),
    .ovf_c (ovf_rt_c)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ctrl_en_q    <= 1'b0;
      pending_q    <= 1'b0;
      snap_valid_q <= 1'b0;
      ovf_q        <= 1'b0;
      shadow_q     <= '0;
      snap_rt_q    <= '0;
    end else begin
      if (wr_c && addr_c == OffCtrl) ctrl_en_q <= pwdata_i[0];
      if (vinsn_valid_i)    pending_q <= 1'b1;
      else if (snap_take_c) pending_q <= 1'b0;
      if (snap_take_c) snap_valid_q <= 1'b1;
      else if (st_wr_c && pwdata_i[StSnapValid]) snap_valid_q <= 1'b0;
      if (ovf_any_c) ovf_q <= 1'b1;
      else if (clr_c || (st_wr_c && pwdata_i[StOvf])) ovf_q <= 1'b0;
      if (rd_c && shadow_ld_c) shadow_q <= shadow_d_c;
      if (snap_take_c) snap_rt_q <= cnt_rt_c;
    end
  end

`ifdef ARA_PERF_STALL_CNT_EN
  logic [CntWidth-1:0] cnt_dc_c, cnt_ic_c, cnt_sb_c;
  logic                ovf_dc_c, ovf_ic_c, ovf_sb_c;

  ara_perf_counter u_cnt_dc (
    .clk (clk_i), .rst_n (rst_ni), .clr (clr_c), .inc (inc_c & dcache_miss_i),
    .cnt_c (cnt_dc_c), .ovf_c (ovf_dc_c)
  );
  ara_perf_counter u_cnt_ic (
    .clk (clk_i), .rst_n (rst_ni), .clr (clr_c), .inc (inc_c & icache_miss_i),
    .cnt_c (cnt_ic_c), .ovf_c (ovf_ic_c)
  );
  ara_perf_counter u_cnt_sb (
    .clk (clk_i), .rst_n (rst_ni), .clr (clr_c), .inc (inc_c & sb_full_i),
    .cnt_c (cnt_sb_c), .ovf_c (ovf_sb_c)
  );

  assign ovf_stall_c = ovf_dc_c | ovf_ic_c | ovf_sb_c;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      snap_dc_q <= '0;
      snap_ic_q <= '0;
      snap_sb_q <= '0;
    end else if (snap_take_c) begin
      snap_dc_q <= cnt_dc_c;
      snap_ic_q <= cnt_ic_c;
      snap_sb_q <= cnt_sb_c;
    end
  end
`else
  logic unused_stall_c;
  assign unused_stall_c = dcache_miss_i ^ icache_miss_i ^ sb_full_i;
  assign ovf_stall_c    = 1'b0;
  assign snap_dc_q      = '0;
  assign snap_ic_q      = '0;
  assign snap_sb_q      = '0;
`endif

endmodule

// File: doc/ara_perf_apb_regs.md
# ara_perf_apb_regs

Synthesizable vector-runtime and CVA6 stall counter engine with an APB register file, placed inside the SoC next to the mock UART on the peripheral APB. It consumes live Ara dispatch/idle and CVA6 perf-event strobes, counts while a software-armed window is open, snapshots the counts when Ara drains, and lets software read them as atomic 64-bit values. The test harness reads the snapshot registers instead of probing hierarchy.

## Interface
Parameters:
- AddrWidth, 32, APB address width; only bits [5:0] are decoded.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- vinsn_valid_i  in  1  vector instruction request valid to Ara
- ara_idle_i  in  1  Ara idle
- dcache_miss_i / icache_miss_i / sb_full_i  in  1 each  CVA6 per-cycle event strobes
- psel_i, penable_i, pwrite_i  in  1 each  APB control
- paddr_i  in  AddrWidth  APB address
- pwdata_i  in  32  APB write data
- prdata_o  out  32  APB read data
- pready_o  out  1  constant 1 (zero wait states)
- pslverr_o  out  1  APB error
- hw_cnt_en_o  out  1  CTRL.EN mirror
- snap_valid_o  out  1  snapshot available

## Operation
- Register map (32-bit): 0x00 CTRL (bit0 EN, RW); 0x04 STATUS (bit0 RUNNING, bit1 PENDING, bit2 SNAP_VALID W1C, bit3 OVF W1C); 0x08/0x0C RUNTIME lo/hi; 0x10/0x14 DCACHE lo/hi; 0x18/0x1C ICACHE lo/hi; 0x20/0x24 SBFULL lo/hi (all snapshot, RO); 0x28 CLEAR (WO, bit0 zeroes live counters and OVF).
- FSM IDLE/COUNTING/DRAINING:
  - IDLE→COUNTING when EN & vinsn_valid_i.
  - COUNTING→IDLE when !EN & ara_idle_i; COUNTING→DRAINING when !EN & !ara_idle_i.
  - DRAINING→IDLE when ara_idle_i; DRAINING→COUNTING when EN.
- RUNNING = state != IDLE. Live runtime counter +1 per cycle in COUNTING/DRAINING; each stall counter +1 per cycle its strobe is high in those states.
- PENDING set on vinsn_valid_i; when PENDING & ara_idle_i & !vinsn_valid_i: all four snapshot regs <= live counts, PENDING cleared, SNAP_VALID set.
- Counters 64-bit saturating at 2^64-1; any saturation sets OVF (sticky).
- Atomic read: reading any lo word latches the matching hi word into a shadow; subsequent hi read returns the shadow. Hi read without prior lo returns the shadow's last value.
- Unmapped address, write to RO, or read of CLEAR: pslverr_o=1, prdata_o=0, no state change.

## Timing
- Reset: state IDLE, all counters/snapshots/shadow 0, CTRL 0, STATUS 0, prdata_o 0, pslverr_o 0, hw_cnt_en_o 0, snap_valid_o 0; pready_o 1.
- APB access completes in the access phase (psel & penable); prdata_o/pslverr_o are combinational from current registers; writes take effect next edge.
- Counting starts the cycle after the IDLE→COUNTING edge: first dispatch at cycle t gives runtime 1 at end of t+1.
- Simultaneous: CLEAR and increment → clear wins (0). Snapshot and CLEAR same cycle → snapshot captures pre-clear counts. SNAP_VALID W1C and new snapshot same cycle → set wins. EN write 0 and vinsn_valid_i in IDLE same cycle → stays IDLE.
- Reset mid-count aborts everything; no partial snapshot.

## Configuration
- ARA_PERF_STALL_CNT_EN defined: DCACHE/ICACHE/SBFULL counters and snapshots implemented.
- Undefined: those three are not instantiated, their registers read 0 without error, strobe inputs ignored; RUNTIME and FSM unchanged.

## Structure
- ara_perf_pkg: register offset localparams, STATUS bit indices, perf_state_e enum.
- Sub-module ara_perf_counter: 64-bit saturating counter with clear, increment enable, overflow pulse; instantiated four times (one with ARA_PERF_STALL_CNT_EN undefined).

## Test plan
- Write CTRL=1, pulse vinsn_valid_i one cycle, ara_idle_i low 10 cycles then high → RUNTIME=11 after snapshot, SNAP_VALID=1, state IDLE after CTRL=0.
- CTRL=0 while ara_idle_i low → state DRAINING, runtime keeps counting until idle; RUNNING=1 throughout.
- dcache_miss_i high 3 cycles inside window, 5 outside → DCACHE lo=3 (with macro); reads 0, pslverr 0 without macro.
- Preload runtime to 2^64-2 (force via counter), run 3 cycles → RUNTIME=0xFFFF_FFFF_FFFF_FFFF, OVF=1; W1C 0x8 to STATUS → OVF=0.
- Read RUNTIME lo, then snapshot updates, then read hi → hi equals pre-update shadow value.
- Access paddr 0x30 and write to 0x08 → pslverr_o=1, prdata_o=0, no register change.
